// File: rtl/led_flow_ctrl.sv
// Flowing-water LED pattern engine: steps an N-bit pattern on each upstream carry tick.
// Optional macro LED_FLOW_BOUNCE_EN enables bounce mode (10); otherwise mode 10 rotates left.
module led_flow_ctrl #(
    parameter int N        = 8,
    parameter int LAP_BITS = 4
) (
    input  logic                clk,
    input  logic                r_n,
    input  logic                tick,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    output logic [N-1:0]        led,
    output logic                running,
    output logic                lap,
    output logic [LAP_BITS-1:0] lap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [N-1:0] LED_FIRST = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] LED_LAST  = {1'b1, {(N-1){1'b0}}};

    state_t              state_q, state_d;
    logic [N-1:0]        led_q, led_d;
    logic [1:0]          mode_q, mode_d;
    logic                running_q, running_d;
    logic                lap_q, lap_d;
    logic [LAP_BITS-1:0] lap_cnt_q, lap_cnt_d;
    logic [N-1:0]        step_led;
`ifdef LED_FLOW_BOUNCE_EN
    logic                dir_up_q, dir_up_d, step_dir_up;
`endif

    function automatic logic [N-1:0] start_pattern(input logic [1:0] m);
        return (m == 2'b01) ? LED_LAST : LED_FIRST;
    endfunction

    // One pattern step for the latched mode; the lap test compares against the start pattern.
    always_comb begin
        step_led = {led_q[N-2:0], led_q[N-1]};
`ifdef LED_FLOW_BOUNCE_EN
        step_dir_up = dir_up_q;
`endif
        case (mode_q)
            2'b01: step_led = {led_q[0], led_q[N-1:1]};
`ifdef LED_FLOW_BOUNCE_EN
            2'b10: begin
                if (dir_up_q) begin
                    step_led = led_q << 1;
                    if (step_led[N-1]) step_dir_up = 1'b0;
                end else begin
                    step_led = led_q >> 1;
                    if (step_led[0]) step_dir_up = 1'b1;
                end
            end
`endif
            2'b11: step_led = (&led_q) ? LED_FIRST : {led_q[N-2:0], 1'b1};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        mode_d    = mode_q;
        lap_d     = 1'b0;
        lap_cnt_d = lap_cnt_q;
`ifdef LED_FLOW_BOUNCE_EN
        dir_up_d  = dir_up_q;
`endif
        case (state_q)
            S_IDLE: begin
                led_d = '0;
                if (start) begin
                    state_d   = S_RUN;
                    mode_d    = mode;
                    led_d     = start_pattern(mode);
                    lap_cnt_d = '0;
`ifdef LED_FLOW_BOUNCE_EN
                    dir_up_d  = 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    led_d = step_led;
`ifdef LED_FLOW_BOUNCE_EN
                    dir_up_d = step_dir_up;
`endif
                    if (step_led == start_pattern(mode_q)) begin
                        lap_d     = 1'b1;
                        lap_cnt_d = lap_cnt_q + LAP_BITS'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = '0;
            end
        endcase
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q   <= S_IDLE;
            led_q     <= '0;
            mode_q    <= 2'b00;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            lap_cnt_q <= '0;
`ifdef LED_FLOW_BOUNCE_EN
            dir_up_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            lap_cnt_q <= lap_cnt_d;
`ifdef LED_FLOW_BOUNCE_EN
            dir_up_q  <= dir_up_d;
`endif
        end
    end

    assign led     = led_q;
    assign running = running_q;
    assign lap     = lap_q;
    assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (N=8, LAP_BITS=4); expectations are hand-derived.
module tb_led_flow_ctrl;

    logic       clk = 1'b0;
    logic       r_n;
    logic       tick, start, stop;
    logic [1:0] mode;
    logic [7:0] led;
    logic       running, lap;
    logic [3:0] lap_cnt;

    int tests  = 0;
    int errors = 0;

    led_flow_ctrl #(.N(8), .LAP_BITS(4)) dut (
        .clk     (clk),
        .r_n     (r_n),
        .tick    (tick),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .led     (led),
        .running (running),
        .lap     (lap),
        .lap_cnt (lap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // One clock with the given controls; outputs are settled 1ns after the edge.
    task automatic cyc(input logic st, input logic sp, input logic tk);
        start = st;
        stop  = sp;
        tick  = tk;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        int  exp_led;
        int  exp_lap;
        r_n   = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'b00;
        #3;
        check_val("rst_led", 32'(led), 32'h0);
        check_val("rst_running", 32'(running), 32'h0);
        check_val("rst_lap", 32'(lap), 32'h0);
        check_val("rst_lap_cnt", 32'(lap_cnt), 32'h0);
        #9 r_n = 1'b1;

        // Rotate left
        mode = 2'b00;
        cyc(1, 0, 0);
        check_val("rl_load", 32'(led), 32'h01);
        check_val("rl_running", 32'(running), 32'h1);
        for (int t = 1; t <= 9; t++) begin
            cyc(0, 0, 1);
            exp_led = 1 << (t % 8);
            exp_lap = (t == 8) ? 1 : 0;
            check_val($sformatf("rl_led_t%0d", t), 32'(led), 32'(exp_led));
            check_val($sformatf("rl_lap_t%0d", t), 32'(lap), 32'(exp_lap));
        end
        check_val("rl_lap_cnt", 32'(lap_cnt), 32'h1);

        // Rotate right
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check_val("to_idle_led", 32'(led), 32'h0);
        mode = 2'b01;
        cyc(1, 0, 0);
        check_val("rr_load", 32'(led), 32'h80);
        check_val("rr_cnt_clear", 32'(lap_cnt), 32'h0);
        for (int t = 1; t <= 8; t++) begin
            cyc(0, 0, 1);
            exp_led = 8'h80 >> (t % 8);
            exp_lap = (t == 8) ? 1 : 0;
            check_val($sformatf("rr_led_t%0d", t), 32'(led), 32'(exp_led));
            check_val($sformatf("rr_lap_t%0d", t), 32'(lap), 32'(exp_lap));
        end
        check_val("rr_lap_cnt", 32'(lap_cnt), 32'h1);

        // Bounce (or rotate left when bounce is compiled out); mode change mid-run is ignored
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        mode = 2'b10;
        cyc(1, 0, 0);
        mode = 2'b11;
        check_val("bn_load", 32'(led), 32'h01);
        for (int t = 1; t <= 14; t++) begin
            cyc(0, 0, 1);
`ifdef LED_FLOW_BOUNCE_EN
            exp_led = (t <= 7) ? (1 << t) : (1 << (14 - t));
            exp_lap = (t == 14) ? 1 : 0;
`else
            exp_led = 1 << (t % 8);
            exp_lap = (t == 8) ? 1 : 0;
`endif
            check_val($sformatf("bn_led_t%0d", t), 32'(led), 32'(exp_led));
            check_val($sformatf("bn_lap_t%0d", t), 32'(lap), 32'(exp_lap));
        end

        // Fill
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        mode = 2'b11;
        cyc(1, 0, 0);
        check_val("fl_load", 32'(led), 32'h01);
        for (int t = 1; t <= 8; t++) begin
            cyc(0, 0, 1);
            exp_led = (t == 8) ? 1 : ((1 << (t + 1)) - 1);
            exp_lap = (t == 8) ? 1 : 0;
            check_val($sformatf("fl_led_t%0d", t), 32'(led), 32'(exp_led));
            check_val($sformatf("fl_lap_t%0d", t), 32'(lap), 32'(exp_lap));
        end
        check_val("fl_lap_cnt1", 32'(lap_cnt), 32'h1);
        for (int t = 0; t < 128; t++) cyc(0, 0, 1);
        check_val("fl_wrap_cnt", 32'(lap_cnt), 32'h1);
        check_val("fl_wrap_led", 32'(led), 32'h01);

        // Pause / resume
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        mode = 2'b00;
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check_val("pr_at4", 32'(led), 32'h04);
        cyc(0, 1, 1);
        check_val("pr_pause_led", 32'(led), 32'h04);
        check_val("pr_pause_run", 32'(running), 32'h0);
        for (int t = 0; t < 3; t++) cyc(0, 0, 1);
        check_val("pr_hold_led", 32'(led), 32'h04);
        check_val("pr_hold_run", 32'(running), 32'h0);
        cyc(1, 0, 0);
        check_val("pr_resume_led", 32'(led), 32'h04);
        check_val("pr_resume_run", 32'(running), 32'h1);
        cyc(0, 0, 1);
        check_val("pr_step_led", 32'(led), 32'h08);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check_val("pr_idle_led", 32'(led), 32'h00);
        check_val("pr_idle_run", 32'(running), 32'h0);
        cyc(1, 0, 1);
        check_val("pr_start_tick", 32'(led), 32'h01);
        cyc(1, 1, 0);
        check_val("pr_both_run", 32'(running), 32'h0);
        check_val("pr_both_led", 32'(led), 32'h01);
        cyc(1, 0, 0);
        check_val("pr_both_resume", 32'(running), 32'h1);

        // Asynchronous reset mid-run
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        mode = 2'b00;
        cyc(1, 0, 0);
        for (int t = 0; t < 28; t++) cyc(0, 0, 1);
        check_val("ar_pre_led", 32'(led), 32'h10);
        check_val("ar_pre_cnt", 32'(lap_cnt), 32'h3);
        #2 r_n = 1'b0;
        #1;
        check_val("ar_led", 32'(led), 32'h00);
        check_val("ar_cnt", 32'(lap_cnt), 32'h0);
        check_val("ar_run", 32'(running), 32'h0);
        #2 r_n = 1'b1;
        for (int t = 0; t < 3; t++) cyc(0, 0, 1);
        check_val("ar_tick_led", 32'(led), 32'h00);
        check_val("ar_tick_run", 32'(running), 32'h0);
        cyc(1, 0, 0);
        check_val("ar_restart_led", 32'(led), 32'h01);
        check_val("ar_restart_cnt", 32'(lap_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
